// File: rtl/tsmac_rxckli_fifo.sv
// tsmac_rxckli_fifo
// Single-clock receive-side FIFO between the TSMAC receive logic and its
// downstream consumer. Registered full/empty and almost-full/almost-empty
// flags, one-cycle read latency by default.
// Optional feature macro: TSMAC_FIFO_OUTPUT_REG_EN adds a second output
// register stage after the read port (read latency becomes two cycles).
module tsmac_rxckli_fifo #(
  parameter int DATA_WIDTH       = 10,
  parameter int DEPTH_WIDTH      = 5,
  parameter int ALMOST_FULL_NUM  = 28,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  wr_full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty,
  output logic                  almost_empty
);

  localparam int                   DEPTH    = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] DEPTH_C  = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0] ONE_C    = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH:0] ZERO_C   = {(DEPTH_WIDTH+1){1'b0}};
  localparam logic [DEPTH_WIDTH:0] AF_C     = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0] AE_C     = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

  // Storage array; deliberately not reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DEPTH_WIDTH:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  wr_full_q, wr_full_d;
  logic                  rd_empty_q, rd_empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;

  logic                  wr_accept_s;
  logic                  rd_accept_s;

  // Gate requests with the current registered flags only.
  assign wr_accept_s = wr_en & ~wr_full_q;
  assign rd_accept_s = rd_en & ~rd_empty_q;

  // Next-state for pointers, occupancy, read data and flags.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    rd_data_d      = rd_data_q;

    if (wr_accept_s) begin
      wr_ptr_d = wr_ptr_q + ONE_C;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_accept_s) begin
      rd_ptr_d  = rd_ptr_q + ONE_C;
      rd_data_d = mem_q[rd_ptr_q[DEPTH_WIDTH-1:0]];
    end else begin
      rd_ptr_d  = rd_ptr_q;
      rd_data_d = rd_data_q;
    end

    case ({wr_accept_s, rd_accept_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    // Flags describe occupancy after this edge.
    wr_full_d      = (count_d == DEPTH_C);
    rd_empty_d     = (count_d == ZERO_C);
    almost_full_d  = (count_d >= AF_C);
    almost_empty_d = (count_d <= AE_C);
  end

  // State, read-data and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q       <= ZERO_C;
      rd_ptr_q       <= ZERO_C;
      count_q        <= ZERO_C;
      rd_data_q      <= {DATA_WIDTH{1'b0}};
      wr_full_q      <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rd_data_q      <= rd_data_d;
      wr_full_q      <= wr_full_d;
      rd_empty_q     <= rd_empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  // Array write port; a reset cycle blocks any simultaneous write.
  always_ff @(posedge clk) begin
    if (rst_n && wr_accept_s) begin
      mem_q[wr_ptr_q[DEPTH_WIDTH-1:0]] <= wr_data;
    end
  end

`ifdef TSMAC_FIFO_OUTPUT_REG_EN
  logic [DATA_WIDTH-1:0] out_q;

  // Extra output stage: follows the read register every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= {DATA_WIDTH{1'b0}};
    end else begin
      out_q <= rd_data_q;
    end
  end

  assign rd_data = out_q;
`else
  assign rd_data = rd_data_q;
`endif

  assign wr_full      = wr_full_q;
  assign rd_empty     = rd_empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;

endmodule

// File: tb/tb_tsmac_rxckli_fifo.sv
// Self-checking bench for tsmac_rxckli_fifo. A queue models FIFO contents;
// words leaving it on an accepted read are pushed to a scoreboard and popped
// when the DUT presents them on rd_data.
module tb_tsmac_rxckli_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] wr_data;
  logic       wr_en;
  logic       rd_en;
  logic       wr_full;
  logic       almost_full;
  logic [9:0] rd_data;
  logic       rd_empty;
  logic       almost_empty;

  always #5 clk = ~clk;

  tsmac_rxckli_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .wr_full      (wr_full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_empty     (rd_empty),
    .almost_empty (almost_empty)
  );

  logic [9:0] mq [$];   // words currently held by the FIFO
  logic [9:0] sb [$];   // words read out, awaiting appearance on rd_data
  logic [9:0] hold;     // value of the first read register stage
  int         n_total = 0;
  int         n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_flags();
    int c;
    c = mq.size();
    check_eq("wr_full",      {31'd0, wr_full},      (c == 32) ? 32'd1 : 32'd0);
    check_eq("rd_empty",     {31'd0, rd_empty},     (c == 0)  ? 32'd1 : 32'd0);
    check_eq("almost_full",  {31'd0, almost_full},  (c >= 28) ? 32'd1 : 32'd0);
    check_eq("almost_empty", {31'd0, almost_empty}, (c <= 4)  ? 32'd1 : 32'd0);
  endtask

  // Hold reset for n cycles with requests asserted (reset must win).
  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n   = 1'b0;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 10'h155;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      mq.delete();
      sb.delete();
      hold = 10'h000;
      check_flags();
      check_eq("rd_data_rst", {22'd0, rd_data}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // One clock of stimulus with model update and output checks.
  task automatic step(input logic w, input logic [9:0] d, input logic r);
    bit         wa;
    bit         ra;
    logic [9:0] nh;
    logic [9:0] exp_rd;
    @(negedge clk);
    rst_n   = 1'b1;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    wa = w && (mq.size() < 32);
    ra = r && (mq.size() != 0);
    if (ra) sb.push_back(mq.pop_front());
    if (wa) mq.push_back(d);
    @(posedge clk);
    #1;
    nh = hold;
    if (ra) nh = sb.pop_front();
`ifdef TSMAC_FIFO_OUTPUT_REG_EN
    exp_rd = hold;
`else
    exp_rd = nh;
`endif
    hold = nh;
    check_flags();
    check_eq("rd_data", {22'd0, rd_data}, {22'd0, exp_rd});
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 10'h000;
    hold    = 10'h000;

    // Reset for 20 cycles.
    do_reset(20);

    // Fill: 33 writes of 0x3FF downward; the 33rd is dropped.
    for (int i = 0; i < 33; i++) step(1'b1, 10'(10'h3FF - i), 1'b0);
    check_eq("full_after_fill", {31'd0, wr_full}, 32'd1);

    // Write while full with a simultaneous read: write dropped, read done.
    step(1'b1, 10'h2AA, 1'b1);
    step(1'b1, 10'h3E0 - 10'd1, 1'b0);

    // Drain: 33 reads then idle cycles to flush the output pipeline.
    for (int i = 0; i < 33; i++) step(1'b0, 10'h000, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 10'h000, 1'b0);
    check_eq("empty_after_drain", {31'd0, rd_empty}, 32'd1);

    // Simultaneous: 10 stored, then 8 cycles of read+write.
    for (int i = 0; i < 10; i++) step(1'b1, 10'(10'h100 + i), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 10'(10'h200 + i), 1'b1);
    check_eq("count_simul", 32'(mq.size()), 32'd10);
    for (int i = 0; i < 12; i++) step(1'b0, 10'h000, 1'b1);
    step(1'b0, 10'h000, 1'b0);

    // Read while empty leaves rd_data unchanged.
    step(1'b0, 10'h000, 1'b1);
    step(1'b0, 10'h000, 1'b1);

    // Reset mid-fill discards stored words.
    for (int i = 0; i < 5; i++) step(1'b1, 10'(10'h0A0 + i), 1'b0);
    do_reset(1);
    for (int i = 0; i < 3; i++) step(1'b0, 10'h000, 1'b1);

    // Random mixed traffic.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 99) < 55), 10'($urandom), 1'($urandom_range(0, 99) < 50));
    for (int i = 0; i < 40; i++) step(1'b0, 10'h000, 1'b1);
    step(1'b0, 10'h000, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
